sha_arbiter: RTL and testbench
==============================

Name: sha_arbiter

Overview:
- Shares the single SHA-256 core between NUM_REQ hash clients: firmware authentication, key derivation and the boot measurement unit.
- Grants the core to one client for a whole multi-block hash session, using round-robin order.
- Registers that client's init, next and block onto the core. Routes ready, digest and digest_valid back to that client only.
- A watchdog revokes the grant from a client that stalls mid-session.

Parameters:
- NUM_REQ, 3, number of requesting clients (2..8).
- BLOCK_W, 512, SHA message block width.
- DIGEST_W, 256, SHA digest width.
- TIMEOUT_CYCLES, 4096, maximum idle cycles during a held grant before it is revoked.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  NUM_REQ  per-client session request; held high for the whole session.
- req_init  input  NUM_REQ  per-client single-cycle init strobe.
- req_next  input  NUM_REQ  per-client single-cycle next strobe.
- req_block  input  NUM_REQ*BLOCK_W  per-client blocks; client i occupies bits [i*BLOCK_W +: BLOCK_W].
- gnt  output  NUM_REQ  one-hot grant.
- gnt_id  output  $clog2(NUM_REQ)  index of the granted client; 0 when idle.
- busy  output  1  a grant is active.
- cli_ready  output  NUM_REQ  core ready, routed to the granted client only.
- cli_digest_valid  output  NUM_REQ  core digest_valid, routed to the granted client only.
- cli_digest  output  DIGEST_W  core digest while busy; 0 otherwise.
- abort  output  NUM_REQ  one-cycle pulse to a client whose grant was revoked.
- timeout_err  output  1  sticky error flag; cleared only by reset.
- sha_init  output  1  init strobe to the core.
- sha_next  output  1  next strobe to the core.
- sha_block  output  BLOCK_W  block to the core.
- sha_ready  input  1  core ready.
- sha_digest_valid  input  1  core digest valid.
- sha_digest  input  DIGEST_W  core digest.

Behaviour:
- Reset values: all outputs 0. State IDLE, round-robin pointer 0, watchdog counter 0, revoked mask 0.
- States: IDLE, GRANTED, RELEASE.
- IDLE:
  - Eligible clients are those with req=1 and revoked[i]=0.
  - If any client is eligible, pick the first one at or after the pointer, wrapping modulo NUM_REQ.
  - Next cycle: gnt=onehot(i), gnt_id=i, busy=1, go to GRANTED.
  - Pointer becomes (i+1) mod NUM_REQ.
- GRANTED:
  - sha_init and sha_next are the granted client's strobes, registered; latency 1 cycle.
  - sha_block is the granted client's block, registered.
  - Strobes from non-granted clients are ignored and produce no core activity.
  - Leaving GRANTED:
    - Granted client drops req: go to RELEASE.
    - Watchdog expiry: go to RELEASE.
- Routing is combinational:
  - cli_ready[i] = sha_ready & gnt[i].
  - cli_digest_valid[i] = sha_digest_valid & gnt[i].
- Watchdog (GRANTED only):
  - Counter increments each cycle and resets to 0 on any of: req_init or req_next from the granted client, or sha_ready=0 (core working).
  - Counter reaching TIMEOUT_CYCLES-1 expires the watchdog:
    - abort[i] pulses for 1 cycle.
    - timeout_err is set.
    - revoked[i] is set.
    - Go to RELEASE.
- RELEASE (exactly 1 cycle):
  - gnt=0, busy=0, sha_init=0, sha_next=0, sha_block=0.
  - Then go to IDLE. Consecutive sessions are therefore separated by at least 1 idle cycle.
- revoked[i] clears when req[i]=0 is sampled. A revoked client must drop req before it can be granted again.
- Simultaneous events:
  - Release and a new request in the same cycle: the new request waits until IDLE. It is never granted in RELEASE.
  - Granted client drops req in the same cycle as watchdog expiry: treat as a normal release. No abort, no error.
  - Init and next asserted together: forward both unchanged. The core's behaviour is undefined; the arbiter does not filter it.
- Reset mid-session: all state and outputs return to reset values immediately. The core's own reset must be tied to the same rst_n.
- Unused gnt_id encodings never occur.

Test Plan:
- Single client: req[0]=1, init, then next ×8 with sha_ready handshakes -> gnt=3'b001 one cycle after req; each strobe appears on the core 1 cycle later; digest reaches cli_digest_valid[0] only.
- Contention: req=3'b111 from reset -> grant order 0,1,2,0. Each session ends with one RELEASE cycle (gnt=0), so the next grant comes 2 cycles after the previous client drops req.
- Non-granted strobe: client 1 pulses req_init while client 0 is granted -> sha_init stays 0; cli_ready[1]=0 throughout.
- Watchdog: client 2 granted, TIMEOUT_CYCLES=16, no strobes, sha_ready=1 -> abort[2] pulse on the 16th cycle; timeout_err=1; client 2 is not regranted until it drops and reasserts req.
- Drop on expiry cycle: req[0] falls exactly on the expiry cycle -> abort=0, timeout_err stays 0.
- Reset mid-session: rst_n low during client 1's next strobe -> all outputs 0 asynchronously; after release, pointer=0 and client 0 is granted first.

Source files
------------

// File: rtl/sha_arbiter.sv
// rtl/sha_arbiter.sv - round-robin session arbiter sharing one SHA-256 core between clients
module sha_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int BLOCK_W        = 512,
    parameter int DIGEST_W       = 256,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           req_init,
    input  logic [NUM_REQ-1:0]           req_next,
    input  logic [NUM_REQ*BLOCK_W-1:0]   req_block,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [$clog2(NUM_REQ)-1:0]   gnt_id,
    output logic                         busy,
    output logic [NUM_REQ-1:0]           cli_ready,
    output logic [NUM_REQ-1:0]           cli_digest_valid,
    output logic [DIGEST_W-1:0]          cli_digest,
    output logic [NUM_REQ-1:0]           abort,
    output logic                         timeout_err,
    output logic                         sha_init,
    output logic                         sha_next,
    output logic [BLOCK_W-1:0]           sha_block,
    input  logic                         sha_ready,
    input  logic                         sha_digest_valid,
    input  logic [DIGEST_W-1:0]          sha_digest
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, GRANTED, RELEASE} state_t;

    state_t             state, state_n;
    logic [IDW-1:0]     ptr, ptr_n;
    logic [WDW-1:0]     wd, wd_n;
    logic [NUM_REQ-1:0] revoked, revoked_n;
    logic [NUM_REQ-1:0] gnt_n, abort_n;
    logic [IDW-1:0]     gnt_id_n;
    logic               busy_n, terr_n, init_n, next_n;
    logic [BLOCK_W-1:0] block_n, block_sel;
    logic [NUM_REQ-1:0] eligible;
    logic [IDW-1:0]     pick;
    logic               found, activity;
    int                 idx;

    assign cli_ready        = gnt & {NUM_REQ{sha_ready}};
    assign cli_digest_valid = gnt & {NUM_REQ{sha_digest_valid}};
    assign cli_digest       = busy ? sha_digest : '0;
    assign eligible         = req & ~revoked;
    assign activity         = req_init[gnt_id] | req_next[gnt_id] | ~sha_ready;

    always_comb begin
        block_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(gnt_id) == i) block_sel = req_block[i*BLOCK_W +: BLOCK_W];
        end
    end

    // Scan from the pointer, wrapping, for the first eligible client
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        wd_n      = wd;
        revoked_n = revoked & req;
        gnt_n     = gnt;
        gnt_id_n  = gnt_id;
        busy_n    = busy;
        init_n    = 1'b0;
        next_n    = 1'b0;
        block_n   = sha_block;
        abort_n   = '0;
        terr_n    = timeout_err;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n     = GRANTED;
                    gnt_n       = '0;
                    gnt_n[pick] = 1'b1;
                    gnt_id_n    = pick;
                    busy_n      = 1'b1;
                    wd_n        = '0;
                    ptr_n       = (int'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;
                end
            end
            GRANTED: begin
                init_n  = req_init[gnt_id];
                next_n  = req_next[gnt_id];
                block_n = block_sel;
                // A voluntary drop wins over a coincident watchdog expiry
                if (!req[gnt_id] || (!activity && wd == WDW'(TIMEOUT_CYCLES - 1))) begin
                    if (req[gnt_id]) begin
                        abort_n[gnt_id]   = 1'b1;
                        revoked_n[gnt_id] = 1'b1;
                        terr_n            = 1'b1;
                    end
                    state_n  = RELEASE;
                    gnt_n    = '0;
                    gnt_id_n = '0;
                    busy_n   = 1'b0;
                    init_n   = 1'b0;
                    next_n   = 1'b0;
                    block_n  = '0;
                    wd_n     = '0;
                end else if (activity) begin
                    wd_n = '0;
                end else begin
                    wd_n = wd + 1'b1;
                end
            end
            RELEASE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            wd          <= '0;
            revoked     <= '0;
            gnt         <= '0;
            gnt_id      <= '0;
            busy        <= 1'b0;
            abort       <= '0;
            timeout_err <= 1'b0;
            sha_init    <= 1'b0;
            sha_next    <= 1'b0;
            sha_block   <= '0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            wd          <= wd_n;
            revoked     <= revoked_n;
            gnt         <= gnt_n;
            gnt_id      <= gnt_id_n;
            busy        <= busy_n;
            abort       <= abort_n;
            timeout_err <= terr_n;
            sha_init    <= init_n;
            sha_next    <= next_n;
            sha_block   <= block_n;
        end
    end
endmodule

// File: tb/tb_sha_arbiter.sv
// tb/tb_sha_arbiter.sv - scoreboard bench for sha_arbiter
module tb_sha_arbiter;
    localparam int N  = 3;
    localparam int BW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0, req_init = '0, req_next = '0;
    logic [N*BW-1:0] req_block = '0;
    logic [N-1:0]    gnt, cli_ready, cli_digest_valid, abort;
    logic [1:0]      gnt_id;
    logic            busy, timeout_err, sha_init, sha_next;
    logic [DW-1:0]   cli_digest;
    logic [BW-1:0]   sha_block;
    logic            sha_ready = 1'b1, sha_digest_valid = 1'b0;
    logic [DW-1:0]   sha_digest = '0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [BW+1:0] sb[$];

    sha_arbiter #(.NUM_REQ(N), .BLOCK_W(BW), .DIGEST_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_init(req_init), .req_next(req_next),
        .req_block(req_block), .gnt(gnt), .gnt_id(gnt_id), .busy(busy),
        .cli_ready(cli_ready), .cli_digest_valid(cli_digest_valid), .cli_digest(cli_digest),
        .abort(abort), .timeout_err(timeout_err), .sha_init(sha_init), .sha_next(sha_next),
        .sha_block(sha_block), .sha_ready(sha_ready), .sha_digest_valid(sha_digest_valid),
        .sha_digest(sha_digest)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input int c, input bit i, input bit n, input logic [BW-1:0] blk, input bit fwd);
        req_init[c] = i;
        req_next[c] = n;
        req_block[c*BW +: BW] = blk;
        if (fwd) sb.push_back({i, n, blk});
        @(negedge clk);
        req_init[c] = 1'b0;
        req_next[c] = 1'b0;
    endtask

    task automatic wait_gnt(input string tag, input logic [N-1:0] exp);
        int n = 0;
        while (gnt !== exp && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, gnt, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Every forwarded strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && (sha_init || sha_next)) begin
            if (sb.size() == 0) check("sb_unexpected", {sha_init, sha_next}, 0);
            else check("sb_core", {sha_init, sha_next, sha_block}, sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int order[4] = '{0, 1, 2, 0};
        int gap, k, c;
        logic any_gnt;

        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_busy_id", {busy, gnt_id}, 0);
        check("rst_core", {sha_init, sha_next, sha_block}, 0);
        check("rst_err_abort", {timeout_err, abort}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single client session
        req = 3'b001;
        @(negedge clk);
        check("single_gnt", gnt, 3'b001);
        check("single_busy", {busy, gnt_id}, {1'b1, 2'd0});
        strobe(0, 1, 0, 32'hA5A5_0000, 1);
        sha_ready = 1'b0;
        @(negedge clk);
        sha_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            strobe(0, 0, 1, 32'h1000_0000 + j * 32'h0101, 1);
            sha_ready = 1'b0;
            @(negedge clk);
            sha_ready = 1'b1;
        end
        strobe(1, 1, 0, 32'hDEAD_BEEF, 0);
        check("nongrant_init", sha_init, 0);
        check("nongrant_ready", cli_ready, 3'b001);
        sha_digest = 32'hC0FF_EE11;
        sha_digest_valid = 1'b1;
        #1;
        check("digest_valid", cli_digest_valid, 3'b001);
        check("digest_val", cli_digest, 32'hC0FF_EE11);
        @(negedge clk);
        sha_digest_valid = 1'b0;
        req = 3'b000;
        @(negedge clk);
        check("single_release", {gnt, busy}, 0);
        check("idle_digest", cli_digest, 0);
        repeat (2) @(negedge clk);

        // Contention: round robin from pointer 0
        do_reset();
        req = 3'b111;
        wait_gnt("rr_first", 3'b001);
        for (int s = 0; s < 4; s++) begin
            c = order[s];
            check($sformatf("rr_gnt%0d", s), gnt, 3'b001 << c);
            check($sformatf("rr_id%0d", s), gnt_id, c);
            repeat (2) @(negedge clk);
            req[c] = 1'b0;
            @(negedge clk);
            check($sformatf("rr_release%0d", s), gnt, 0);
            req[c] = 1'b1;
            if (s < 3) begin
                gap = 1;
                while (gnt == 0 && gap < 10) begin
                    @(negedge clk);
                    if (gnt == 0) gap++;
                end
                check($sformatf("rr_gap%0d", s), gap, 2);
            end
        end
        req = 3'b000;
        repeat (3) @(negedge clk);

        // Drop on the expiry cycle is a normal release
        do_reset();
        req = 3'b001;
        wait_gnt("drop_gnt", 3'b001);
        repeat (15) @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        check("drop_abort", abort, 0);
        check("drop_gnt0", gnt, 0);
        @(negedge clk);
        check("drop_err", timeout_err, 0);

        // Watchdog expiry on client 2
        req = 3'b100;
        wait_gnt("wd_gnt", 3'b100);
        k = 0;
        while (abort == 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("wd_cycles", k, TO);
        check("wd_abort", abort, 3'b100);
        check("wd_err", timeout_err, 1);
        check("wd_gnt0", gnt, 0);
        @(negedge clk);
        check("wd_abort_pulse", abort, 0);
        any_gnt = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (gnt != 0) any_gnt = 1'b1;
        end
        check("wd_no_regrant", any_gnt, 0);
        req[2] = 1'b0;
        @(negedge clk);
        req[2] = 1'b1;
        wait_gnt("wd_regrant", 3'b100);
        check("wd_err_sticky", timeout_err, 1);

        // Reset mid-session during client 1's next strobe
        req = 3'b010;
        wait_gnt("rst_c1_gnt", 3'b010);
        req_next[1] = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("async_gnt", {gnt, busy, gnt_id}, 0);
        check("async_core", {sha_init, sha_next, sha_block}, 0);
        check("async_err", {timeout_err, abort, cli_ready}, 0);
        req_next[1] = 1'b0;
        req = 3'b011;
        @(negedge clk);
        rst_n = 1'b1;
        wait_gnt("rst_first", 3'b001);
        req = 3'b000;
        repeat (3) @(negedge clk);

        check("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
